// File: rtl/gf_pkg.sv
// ---------------------------------------------------------------------------
// gf_pkg
// Shared definitions for the GF(2^8) polynomial datapath.
//   GF_PRIM  : primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D)
//   GF_BITS  : bits per field element
//   state_t  : control states of the sequential polynomial divider
//   gf_xtime : multiply a field element by x (alpha), reduced by GF_PRIM
// ---------------------------------------------------------------------------
package gf_pkg;

   localparam logic [8:0] GF_PRIM = 9'h11D;
   localparam int         GF_BITS = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INV  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Shift left by one and fold bit 8 back in with the low byte of GF_PRIM.
   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      logic [7:0] red_v;
      red_v = a[7] ? GF_PRIM[7:0] : 8'h00;
      return {a[6:0], 1'b0} ^ red_v;
   endfunction

endpackage

// File: rtl/gf_mul.sv
// ---------------------------------------------------------------------------
// gf_mul
// Combinational GF(2^8) multiplier, modulo 0x11D.
// Ports:
//   a, b : 8-bit field operands
//   p    : 8-bit field product a*b
// Squaring is obtained by tying a and b together at the instantiation.
// ---------------------------------------------------------------------------
module gf_mul
   import gf_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] p
);

   // Shift-and-add: accumulate a*x^i for every set bit i of b.
   always_comb begin : mul_proc
      logic [7:0] acc_v;
      logic [7:0] sh_v;
      acc_v = 8'h00;
      sh_v  = a;
      for (int i = 0; i < GF_BITS; i++) begin
         if (b[i]) begin
            acc_v = acc_v ^ sh_v;
         end else begin
            acc_v = acc_v;
         end
         sh_v = gf_xtime(sh_v);
      end
      p = acc_v;
   end

endmodule

// File: rtl/gf_poly_div.sv
// ---------------------------------------------------------------------------
// gf_poly_div
// Sequential GF(2^8) polynomial long divider: Z(x) = Q(x)*D(x) + R(x).
// The dividend has degree 2n, the divisor degree n; the quotient has degree n
// and the remainder degree n-1. Coefficient i sits at bits [i*SIZE +: SIZE].
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   start      : request, accepted only in IDLE and not while done is high
//   flat_z     : dividend, captured on the accepted start
//   flat_q     : divisor, captured on the accepted start
//   busy       : high while inverting / dividing
//   done       : one-cycle pulse, results valid
//   err        : divisor leading coefficient was zero
//   flat_quot  : quotient (zero on err)
//   flat_rem   : remainder (zero on err)
// Flow: IDLE -> INV (7 cycles, leading-coefficient inverse via x^254)
//       -> DIV (n+1 cycles, one quotient coefficient per cycle) -> DONE.
// ---------------------------------------------------------------------------
module gf_poly_div
   import gf_pkg::*;
#(
   parameter int m                = 255,
   parameter int SIZE             = $clog2(m),
   parameter int n                = 2,
   parameter int flat_size        = (n + 1) * SIZE,
   parameter int large_array      = 2 * n,
   parameter int large_array_size = (large_array + 1) * SIZE
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [large_array_size-1:0] flat_z,
   input  logic [flat_size-1:0]        flat_q,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic [flat_size-1:0]        flat_quot,
   output logic [n*SIZE-1:0]           flat_rem
);

   // Counter must reach both the last INV step (GF_BITS-2) and the top degree.
   localparam int CNT_W = ($clog2(large_array + 1) > 3) ? $clog2(large_array + 1) : 3;
   localparam logic [CNT_W-1:0] INV_LAST = CNT_W'(GF_BITS - 2);
   localparam logic [CNT_W-1:0] K_TOP    = CNT_W'(large_array);
   localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(n);

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [CNT_W-1:0]       cnt_r;
   logic [SIZE-1:0]        r_r [0:large_array];
   logic [SIZE-1:0]        d_r [0:n];
   logic [SIZE-1:0]        q_r [0:n];
   logic [SIZE-1:0]        r_nxt_s [0:large_array];
   logic [SIZE-1:0]        sq_r;
   logic [SIZE-1:0]        acc_r;
   logic [SIZE-1:0]        sq2_s;
   logic [SIZE-1:0]        acc_nxt_s;
   logic [SIZE-1:0]        c_in_s;
   logic [SIZE-1:0]        c_s;
   logic [SIZE-1:0]        prod_s [0:n];
   logic [SIZE-1:0]        lead_in_s;
   logic                   start_ok_s;
   logic                   err_r;
   logic                   busy_r;
   logic                   done_r;
   logic [flat_size-1:0]   quot_r;
   logic [n*SIZE-1:0]      rem_r;
   logic [flat_size-1:0]   quot_pk_s;
   logic [n*SIZE-1:0]      rem_pk_s;

   assign lead_in_s  = flat_q[n*SIZE +: SIZE];
   // A start arriving together with the done pulse is dropped.
   assign start_ok_s = start & ~done_r;

   // Inverse datapath: sq <- sq^2, acc <- acc*sq^2.
   gf_mul u_sq  (.a(sq_r),  .b(sq_r),  .p(sq2_s));
   gf_mul u_acc (.a(acc_r), .b(sq2_s), .p(acc_nxt_s));

   // Select R[k] for the current division step k = cnt_r.
   always_comb begin
      c_in_s = {SIZE{1'b0}};
      for (int i = 0; i <= large_array; i++) begin
         if (cnt_r == CNT_W'(i)) begin
            c_in_s = r_r[i];
         end else begin
            c_in_s = c_in_s;
         end
      end
   end

   // Quotient coefficient c = R[k] * inv.
   gf_mul u_c (.a(c_in_s), .b(acc_r), .p(c_s));

   // Products c*D[n-j] to be cancelled out of R[k-j].
   for (genvar j = 0; j <= n; j++) begin : g_prod
      gf_mul u_p (.a(c_s), .b(d_r[n-j]), .p(prod_s[j]));
   end

   // Next work register: R[k-j] ^= c*D[n-j]; index match written as i+j==k.
   always_comb begin
      for (int i = 0; i <= large_array; i++) begin
         r_nxt_s[i] = r_r[i];
         for (int j = 0; j <= n; j++) begin
            if ((CNT_W'(i) + CNT_W'(j)) == cnt_r) begin
               r_nxt_s[i] = r_nxt_s[i] ^ prod_s[j];
            end else begin
               r_nxt_s[i] = r_nxt_s[i];
            end
         end
      end
   end

   // Flatten quotient and low remainder coefficients for the output registers.
   always_comb begin
      quot_pk_s = {flat_size{1'b0}};
      rem_pk_s  = {(n*SIZE){1'b0}};
      for (int i = 0; i <= n; i++) begin
         quot_pk_s[i*SIZE +: SIZE] = q_r[i];
      end
      for (int i = 0; i < n; i++) begin
         rem_pk_s[i*SIZE +: SIZE] = r_r[i];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_ok_s) begin
               state_nxt_s = (lead_in_s == {SIZE{1'b0}}) ? ST_DONE : ST_INV;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_INV: begin
            if (cnt_r == INV_LAST) begin
               state_nxt_s = ST_DIV;
            end else begin
               state_nxt_s = ST_INV;
            end
         end
         ST_DIV: begin
            if (cnt_r == K_LAST) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_DIV;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Datapath registers, step counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r  <= {CNT_W{1'b0}};
         sq_r   <= {SIZE{1'b0}};
         acc_r  <= {SIZE{1'b0}};
         err_r  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         quot_r <= {flat_size{1'b0}};
         rem_r  <= {(n*SIZE){1'b0}};
         for (int i = 0; i <= large_array; i++) begin
            r_r[i] <= {SIZE{1'b0}};
         end
         for (int i = 0; i <= n; i++) begin
            d_r[i] <= {SIZE{1'b0}};
            q_r[i] <= {SIZE{1'b0}};
         end
      end else begin
         busy_r <= (state_nxt_s == ST_INV) || (state_nxt_s == ST_DIV);
         done_r <= (state_r == ST_DONE);
         case (state_r)
            ST_IDLE: begin
               if (start_ok_s) begin
                  for (int i = 0; i <= large_array; i++) begin
                     r_r[i] <= flat_z[i*SIZE +: SIZE];
                  end
                  for (int i = 0; i <= n; i++) begin
                     d_r[i] <= flat_q[i*SIZE +: SIZE];
                     q_r[i] <= {SIZE{1'b0}};
                  end
                  // The inverse chain starts straight from the input bus.
                  sq_r   <= lead_in_s;
                  acc_r  <= {{(SIZE-1){1'b0}}, 1'b1};
                  cnt_r  <= {CNT_W{1'b0}};
                  err_r  <= (lead_in_s == {SIZE{1'b0}});
                  quot_r <= {flat_size{1'b0}};
                  rem_r  <= {(n*SIZE){1'b0}};
               end
            end
            ST_INV: begin
               sq_r  <= sq2_s;
               acc_r <= acc_nxt_s;
               cnt_r <= (cnt_r == INV_LAST) ? K_TOP : (cnt_r + CNT_W'(1));
            end
            ST_DIV: begin
               for (int i = 0; i <= large_array; i++) begin
                  r_r[i] <= r_nxt_s[i];
               end
               for (int i = 0; i <= n; i++) begin
                  if (cnt_r == CNT_W'(i + n)) begin
                     q_r[i] <= c_s;
                  end
               end
               cnt_r <= cnt_r - CNT_W'(1);
            end
            ST_DONE: begin
               quot_r <= err_r ? {flat_size{1'b0}} : quot_pk_s;
               rem_r  <= err_r ? {(n*SIZE){1'b0}} : rem_pk_s;
            end
            default: begin
               cnt_r <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign err       = err_r;
   assign flat_quot = quot_r;
   assign flat_rem  = rem_r;

endmodule
